// File: rtl/dshot_rx.sv
// DShot receiver: oversamples the synchronized line, measures pulse widths,
// checks the 4-bit CRC and turns valid throttle words into an 8-bit speed.
module dshot_rx #(
    parameter int CLK_HZ     = 12000000,
    parameter int BIT_RATE   = 600000,
    parameter int TIMEOUT_MS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        dshot_in,
    output logic [7:0]  targetSpeed,
    output logic [10:0] throttle_raw,
    output logic        telem_req,
    output logic        frame_valid,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        failsafe
);

    localparam int BIT_CYC     = CLK_HZ / BIT_RATE;
    localparam int HALF        = BIT_CYC / 2;
    localparam int QUART       = BIT_CYC / 4;
    localparam int GAP         = 2 * BIT_CYC;
    localparam int CNT_W       = $clog2(GAP + 2);
    localparam int LEN_W       = CNT_W + 1;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, CHECK} state_e;

    state_e             state, stateNext;
    logic               dshotSync_p0, dshotSync_p1, dshotPrev_p2;
    logic               rise, fall;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   hiLen;
    logic [4:0]         bitCnt;
    logic [15:0]        shiftReg;
    logic               armed;
    logic               abort, shiftEn;
    logic               crcOk, accept, crcBad, errStrobe, isZero, isCmd;
    logic [10:0]        newThrottle;
    logic [TMR_W-1:0]   timer;

    function automatic logic [3:0] dshotCrc(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    // Maps 48..2047 onto 0..255; the product never exceeds 18 bits.
    function automatic logic [7:0] scaleSpeed(input logic [10:0] t);
        logic [18:0] p;
        p = ({8'd0, t} - 19'd48) * 19'd131;
        return 8'(p >> 10);
    endfunction

    // Stage p0/p1: metastability synchronizer, p2: edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dshotSync_p0 <= 1'b0;
            dshotSync_p1 <= 1'b0;
            dshotPrev_p2 <= 1'b0;
        end else begin
            dshotSync_p0 <= dshot_in;
            dshotSync_p1 <= dshotSync_p0;
            dshotPrev_p2 <= dshotSync_p1;
        end
    end

    assign rise  = dshotSync_p1 & ~dshotPrev_p2;
    assign fall  = ~dshotSync_p1 & dshotPrev_p2;
    assign hiLen = {1'b0, cnt} + LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        abort     = 1'b0;
        shiftEn   = 1'b0;
        if (enable) begin
            case (state)
                IDLE: if (rise && armed) stateNext = HIGH;
                HIGH: begin
                    if (fall) begin
                        if (hiLen < LEN_W'(QUART)) begin
                            abort = 1'b1;
                        end else begin
                            shiftEn   = 1'b1;
                            stateNext = (bitCnt == 5'd15) ? CHECK : LOW;
                        end
                    end else if (cnt >= CNT_W'(BIT_CYC - 1)) begin
                        abort = 1'b1;
                    end
                end
                LOW: begin
                    if (rise)                         stateNext = HIGH;
                    else if (cnt >= CNT_W'(GAP - 1)) abort     = 1'b1;
                end
                CHECK:   stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
            if (abort) stateNext = IDLE;
        end else begin
            stateNext = IDLE;
        end
    end

    always_comb begin
        crcOk       = (shiftReg[3:0] == dshotCrc(shiftReg[15:4]));
        accept      = enable && (state == CHECK) && crcOk;
        crcBad      = enable && (state == CHECK) && !crcOk;
        newThrottle = shiftReg[15:5];
        isZero      = (newThrottle == 11'd0);
        isCmd       = !isZero && (newThrottle < 11'd48);
        errStrobe   = abort || crcBad;
    end

    // A frame may only start once the line has idled low for a full gap after
    // enable or reset, so a frame already in flight is never half-decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            armed    <= 1'b0;
        end else if (!enable) begin
            cnt    <= '0;
            bitCnt <= '0;
            armed  <= 1'b0;
        end else begin
            if (state == IDLE && !dshotSync_p1 && cnt >= CNT_W'(GAP - 1))
                armed <= 1'b1;
            if (stateNext == IDLE && state != IDLE) begin
                cnt    <= '0;
                bitCnt <= '0;
            end else if (stateNext == HIGH && state != HIGH) begin
                cnt <= '0;
            end else if (shiftEn) begin
                shiftReg <= {shiftReg[14:0], hiLen > LEN_W'(HALF)};
                bitCnt   <= bitCnt + 5'd1;
                cnt      <= '0;
            end else if (state == IDLE && dshotSync_p1) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(GAP)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output stage: registered on the edge leaving CHECK; a valid frame beats a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            targetSpeed  <= '0;
            throttle_raw <= '0;
            telem_req    <= 1'b0;
            frame_valid  <= 1'b0;
            cmd_valid    <= 1'b0;
            frame_err    <= 1'b0;
            failsafe     <= 1'b1;
            timer        <= '0;
        end else begin
            frame_valid <= accept;
            cmd_valid   <= accept && isCmd;
            frame_err   <= errStrobe;
            if (accept) begin
                timer        <= '0;
                failsafe     <= 1'b0;
                throttle_raw <= newThrottle;
                telem_req    <= shiftReg[4];
                if (isZero)      targetSpeed <= '0;
                else if (!isCmd) targetSpeed <= scaleSpeed(newThrottle);
            end else if (timer != TMR_W'(TIMEOUT_CYC)) begin
                timer <= timer + TMR_W'(1);
            end else begin
                failsafe    <= 1'b1;
                targetSpeed <= '0;
            end
        end
    end

endmodule

// File: doc/dshot_rx.md
DSHOT_RX -- requirements
Module: dshot_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 600000, meaning DShot bit rate in bit/s; BIT_CYC = CLK_HZ/BIT_RATE (20 at defaults).
REQ-003 SHALL have parameter TIMEOUT_MS, default 100, meaning the no-valid-frame interval after which failsafe asserts.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, meaning receiver enable.
REQ-007 SHALL have port dshot_in, input, 1, meaning asynchronous DShot line from the flight controller.
REQ-008 SHALL have port targetSpeed, output, 8, meaning scaled throttle for the downstream PWM generator.
REQ-009 SHALL have port throttle_raw, output, 11, meaning the last CRC-valid 11-bit value, throttle or command.
REQ-010 SHALL have port telem_req, output, 1, meaning the telemetry bit of the last valid frame.
REQ-011 SHALL have ports frame_valid, cmd_valid and frame_err, each output, 1, meaning one-cycle strobes.
REQ-012 SHALL have port failsafe, output, 1, meaning no valid frame within TIMEOUT_MS.

Function
REQ-013 SHALL pass dshot_in through a 2-flop synchronizer; all edge detection SHALL use the synchronized signal only.
REQ-014 SHALL implement the FSM states IDLE, HIGH, LOW and CHECK.
REQ-015 On a rising edge in IDLE or LOW, the FSM SHALL go to HIGH and clear the pulse counter.
REQ-016 On a falling edge in HIGH, the FSM SHALL shift in the bit, 1 if high count > BIT_CYC/2 and 0 otherwise, MSB first.
REQ-017 After the 16th bit the FSM SHALL go to CHECK; otherwise it SHALL go to LOW.
REQ-018 A high pulse < BIT_CYC/4 cycles or > BIT_CYC cycles SHALL abort the frame: frame_err pulse, return to IDLE, bit count cleared.
REQ-019 In LOW, low time > 2*BIT_CYC before the 16th bit SHALL abort the frame the same way as REQ-018.
REQ-020 In IDLE, any low duration SHALL be legal; an inter-frame gap SHALL NOT raise an error.
REQ-021 CHECK SHALL last one cycle: with v = frame[15:4], the frame is valid iff frame[3:0] == (v ^ v>>4 ^ v>>8) & 0xF.
REQ-022 On a CRC mismatch, the block SHALL pulse frame_err and leave all data outputs unchanged.
REQ-023 On a CRC match, the block SHALL set throttle_raw = frame[15:5] and telem_req = frame[4], pulse frame_valid, and restart the failsafe timer.
REQ-024 If throttle_raw is 0, the block SHALL set targetSpeed to 0.
REQ-025 If throttle_raw is 1..47, the block SHALL pulse cmd_valid and leave targetSpeed unchanged.
REQ-026 If throttle_raw is 48..2047, the block SHALL set targetSpeed = ((throttle_raw-48)*131) >> 10, using a 19-bit unsigned intermediate, giving a result in 0..255.
REQ-027 All output updates and strobes SHALL occur on the clock edge that exits CHECK.
REQ-028 Latency from the synchronized 16th falling edge to the strobe SHALL be exactly 2 clk cycles.
REQ-029 The failsafe timer SHALL count to CLK_HZ/1000*TIMEOUT_MS, then saturate and assert failsafe and force targetSpeed to 0.
REQ-030 A valid frame in the same cycle as the timeout SHALL win: failsafe deasserts and the new speed is applied.
REQ-031 enable low SHALL force the FSM to IDLE and discard any partial frame, with no frame_err.
REQ-032 While enable is low, the failsafe timer SHALL keep running and the outputs SHALL hold their values.
REQ-033 If enable rises mid-frame, the FSM SHALL wait for the next IDLE gap and SHALL NOT decode the partial frame.

Reset
REQ-034 On rst_n low, asynchronously: FSM to IDLE, shift register, bit count and all counters to 0, synchronizer to 0.
REQ-035 On rst_n low, asynchronously: targetSpeed, throttle_raw, telem_req and all strobes to 0, and failsafe to 1.
REQ-036 Reset mid-frame SHALL discard the frame, and failsafe SHALL stay 1 until the first valid frame.

Verification
REQ-037 Valid mid-range frame 0x82E4 (throttle 1047, telem 0) at defaults -> frame_valid pulse, throttle_raw=1047, targetSpeed=127, failsafe=0.
REQ-038 Frames 0x0606 then 0xFFEE -> targetSpeed=0 and then 255, each with a frame_valid pulse 2 cycles after the last falling edge.
REQ-039 Command frame 0x00AA (value 5) after 0x82E4 -> cmd_valid pulse, throttle_raw=5, targetSpeed stays 127.
REQ-040 Frame 0x82E5 (bad CRC), and separately a 10-bit frame followed by a 3-bit-time low gap -> frame_err pulse each, with no output change.
REQ-041 Valid frame then silence for 100 ms -> failsafe=1 and targetSpeed=0; the next valid frame clears failsafe.
REQ-042 rst_n pulsed low at bit 8, and separately enable dropped at bit 8 -> outputs per reset or held, no strobes, and the next full frame decodes correctly.
